// File: rtl/decode_pipe_stage_if.sv
// ============================================================================
// Module   : decode_pipe_stage_if
// Brief    : Bundles the fetch-side handshake, writeback port, flush and the
//            ID/EX payload of the decode pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_pipe_stage_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int CTRL_W = 24,
  parameter int CNT_W  = 16
);
  // Upstream (fetch + control block)
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instr_in;
  logic [PC_W-1:0]   pc_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic              ctrl_err_in;
  logic [2:0]        rd_in;
  logic              rd_wen_in;
  logic              rs_used_in;
  logic              rt_used_in;
  logic              is_load_in;
  // Redirect and writeback
  logic              flush;
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  // Downstream (execute)
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       instr_out;
  logic [PC_W-1:0]   pc_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [2:0]        rd_out;
  logic              rd_wen_out;
  logic              is_load_out;
  logic [DATA_W-1:0] rs_data_out;
  logic [DATA_W-1:0] rt_data_out;
  logic              err_out;
  logic [CNT_W-1:0]  stall_cnt;

  // Surrounding pipeline: drives beats, writeback, flush and out_ready
  modport master (
    output in_valid, instr_in, pc_in, ctrl_in, ctrl_err_in, rd_in, rd_wen_in,
           rs_used_in, rt_used_in, is_load_in, flush, wb_en, wb_addr, wb_data,
           out_ready,
    input  in_ready, out_valid, instr_out, pc_out, ctrl_out, rd_out,
           rd_wen_out, is_load_out, rs_data_out, rt_data_out, err_out,
           stall_cnt
  );

  // Decode stage itself
  modport slave (
    input  in_valid, instr_in, pc_in, ctrl_in, ctrl_err_in, rd_in, rd_wen_in,
           rs_used_in, rt_used_in, is_load_in, flush, wb_en, wb_addr, wb_data,
           out_ready,
    output in_ready, out_valid, instr_out, pc_out, ctrl_out, rd_out,
           rd_wen_out, is_load_out, rs_data_out, rt_data_out, err_out,
           stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/decode_pipe_stage.sv
// ============================================================================
// Module   : decode_pipe_stage
// Brief    : ID/EX pipeline stage: 8-entry register file with write bypass,
//            valid/ready handshake, load-use hazard bubbles, flush, and a
//            saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_pipe_stage #(
  parameter int          DATA_W    = 16,
  parameter int          PC_W      = 16,
  parameter int          CTRL_W    = 24,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  decode_pipe_stage_if.slave bus
);

  logic [DATA_W-1:0] r_regs [8];

  logic              r_outValid;
  logic [15:0]       r_instr;
  logic [PC_W-1:0]   r_pc;
  logic [CTRL_W-1:0] r_ctrl;
  logic [2:0]        r_rd;
  logic              r_rdWen;
  logic              r_isLoad;
  logic [DATA_W-1:0] r_rsData;
  logic [DATA_W-1:0] r_rtData;
  logic              r_err;
  logic [CNT_W-1:0]  r_stallCnt;

  logic [2:0]        w_rsSel;
  logic [2:0]        w_rtSel;
  logic [2:0]        w_heldRs;
  logic [2:0]        w_heldRt;
  logic [DATA_W-1:0] w_rsData;
  logic [DATA_W-1:0] w_rtData;
  logic              w_hazard;
  logic              w_inReady;
  logic              w_accept;

  assign w_rsSel  = bus.instr_in[10:8];
  assign w_rtSel  = bus.instr_in[7:5];
  // Held payload source addresses come straight from the registered word
  assign w_heldRs = r_instr[10:8];
  assign w_heldRt = r_instr[7:5];

  // A same-cycle writeback to the selected register wins over the array
  assign w_rsData = (bus.wb_en && (bus.wb_addr == w_rsSel)) ? bus.wb_data : r_regs[w_rsSel];
  assign w_rtData = (bus.wb_en && (bus.wb_addr == w_rtSel)) ? bus.wb_data : r_regs[w_rtSel];

  // Load in ID/EX whose destination feeds an operand of the incoming beat
  assign w_hazard = r_outValid & r_isLoad & r_rdWen &
                    ((bus.rs_used_in & (r_rd == w_rsSel)) |
                     (bus.rt_used_in & (r_rd == w_rtSel)));

  assign w_inReady = ~bus.flush & ~w_hazard & (~r_outValid | bus.out_ready);
  assign w_accept  = bus.in_valid & w_inReady;

  // Register file write port; register 0 is an ordinary register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.wb_en) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // ID/EX payload: flush, then accept, then bubble, else hold with refresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_ctrl     <= '0;
      r_rd       <= '0;
      r_rdWen    <= 1'b0;
      r_isLoad   <= 1'b0;
      r_rsData   <= '0;
      r_rtData   <= '0;
      r_err      <= 1'b0;
    end else if (bus.flush) begin
      r_outValid <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_ctrl     <= '0;
      r_rdWen    <= 1'b0;
      r_isLoad   <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_instr    <= bus.instr_in;
      r_pc       <= bus.pc_in;
      r_ctrl     <= bus.ctrl_in;
      r_rd       <= bus.rd_in;
      r_rdWen    <= bus.rd_wen_in;
      r_isLoad   <= bus.is_load_in;
      r_rsData   <= w_rsData;
      r_rtData   <= w_rtData;
      r_err      <= bus.ctrl_err_in;
    end else if (r_outValid && bus.out_ready) begin
      r_outValid <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_ctrl     <= '0;
      r_rdWen    <= 1'b0;
      r_isLoad   <= 1'b0;
    end else if (r_outValid) begin
      // Stalled by execute: keep operands coherent with late writebacks
      if (bus.wb_en && (bus.wb_addr == w_heldRs)) begin
        r_rsData <= bus.wb_data;
      end
      if (bus.wb_en && (bus.wb_addr == w_heldRt)) begin
        r_rtData <= bus.wb_data;
      end
    end
  end

  // Count cycles where a valid beat is held back by a load-use hazard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
    end else if (bus.in_valid && w_hazard && !bus.flush && !(&r_stallCnt)) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign bus.in_ready    = w_inReady;
  assign bus.out_valid   = r_outValid;
  assign bus.instr_out   = r_instr;
  assign bus.pc_out      = r_pc;
  assign bus.ctrl_out    = r_ctrl;
  assign bus.rd_out      = r_rd;
  assign bus.rd_wen_out  = r_rdWen;
  assign bus.is_load_out = r_isLoad;
  assign bus.rs_data_out = r_rsData;
  assign bus.rt_data_out = r_rtData;
  assign bus.err_out     = r_err;
  assign bus.stall_cnt   = r_stallCnt;

endmodule

`default_nettype wire

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
Parametrised decode/ID-EX pipeline stage for the 16-bit pipelined core.
- Reads an 8-entry register file with write-to-read bypass.
- Registers the pre-decoded control bundle and operands into the ID/EX boundary.
- Uses a valid/ready handshake, detects load-use hazards, flushes with NOP-bubble insertion, and counts stall cycles.
- Sits between fetch (upstream) and execute (downstream); control decode is done by the separate control block that feeds ctrl_in.

Parameters:
- DATA_W, 16, register/operand data width.
- PC_W, 16, program counter width.
- CTRL_W, 24, width of pre-decoded control bundle (opaque, passed through).
- NOP_INSTR, 16'h0800, instruction word presented on instr_out for bubbles and after reset.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage accepts beat this cycle
- instr_in  in  16  instruction; rs=instr_in[10:8], rt=instr_in[7:5]
- pc_in  in  PC_W  next PC of instruction
- ctrl_in  in  CTRL_W  control bundle from control block
- ctrl_err_in  in  1  control block decode error
- rd_in  in  3  destination register
- rd_wen_in  in  1  instruction writes rd
- rs_used_in, rt_used_in  in  1 each  source operand actually read
- is_load_in  in  1  instruction is a memory load
- flush  in  1  branch/jump redirect; kill stage contents
- wb_en  in  1  writeback enable
- wb_addr  in  3  writeback register
- wb_data  in  DATA_W  writeback data
- out_valid  out  1  ID/EX payload valid
- out_ready  in  1  execute accepts payload
- instr_out  out  16  registered instruction
- pc_out  out  PC_W  registered PC
- ctrl_out  out  CTRL_W  registered control
- rd_out  out  3  registered destination
- rd_wen_out  out  1  registered write enable
- is_load_out  out  1  registered load flag
- rs_data_out, rt_data_out  out  DATA_W  registered operands
- err_out  out  1  registered error for this payload
- stall_cnt  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset (async): all registered outputs 0 except instr_out=NOP_INSTR; out_valid=0; register file all 0; stall_cnt=0.
- Register file: write at clk edge when wb_en. A read whose select equals wb_addr while wb_en=1 returns wb_data in the same cycle (bypass).
- hazard = out_valid & is_load_out & rd_wen_out & ((rs_used_in & rd_out==rs) | (rt_used_in & rd_out==rt)).
- in_ready = ~flush & ~hazard & (~out_valid | out_ready). Combinational; no dependence on in_valid.
- accept = in_valid & in_ready. Latency 1: payload appears on outputs the cycle after accept.
- Next-state priority per clock edge:
  1. flush: out_valid<=0, instr_out<=NOP_INSTR, ctrl_out<=0, rd_wen_out<=0, is_load_out<=0, err_out<=0. The incoming beat is dropped.
  2. accept: load all payload registers; out_valid<=1; err_out<=ctrl_err_in.
  3. out_valid & out_ready without accept (including hazard): bubble; out_valid<=0, instr_out<=NOP_INSTR, ctrl_out<=0, rd_wen_out<=0, is_load_out<=0.
  4. Otherwise hold all outputs.
- Hold refresh: while holding (out_valid & ~out_ready & ~flush), a wb_en write whose wb_addr equals the held rs (or rt) updates rs_data_out (or rt_data_out) with wb_data. Held rs/rt addresses are stored internally from instr_out.
- Hazard resolution: a load-use hazard always yields exactly one bubble once execute takes the load. A hazard while execute is stalled (out_ready=0) adds no extra bubble.
- stall_cnt increments when in_valid & hazard & ~flush, and saturates at all-ones.
- Simultaneous flush and hazard: flush wins; the counter does not increment.
- Simultaneous wb write and accept to the same source: the new data is captured via bypass.
- Writing register 0 is a normal write; there is no hard-wired zero register.

Test Plan:
- Reset mid-operation: rst asserted while out_valid=1 -> immediately out_valid=0, instr_out=16'h0800, stall_cnt=0; in_ready=1 after release.
- Bypass: wb_en=1, wb_addr=3, wb_data=16'hBEEF, same cycle accept instr rs=3 -> next cycle rs_data_out=16'hBEEF.
- Load-use: load rd=2 accepted; next instr rs=2, rs_used_in=1, out_ready=1 -> in_ready=0 one cycle, one bubble (out_valid=0, instr_out=16'h0800), dependent accepted next cycle, stall_cnt=1.
- Backpressure + refresh: out_ready=0 for 3 cycles holding instr rt=5; wb_en writes r5=16'h1234 -> outputs otherwise unchanged, rt_data_out=16'h1234, in_ready=0 throughout.
- Flush: flush=1 with in_valid=1 and out_valid=1 -> in_ready=0, next cycle out_valid=0, ctrl_out=0, instr_out=16'h0800; incoming beat is never emitted.
- Counter saturation (CNT_W=2): hold a load-use hazard 5 cycles with out_ready=0 -> stall_cnt reaches 3 and stays at 3.
